// File: rtl/sorted_stream_if.sv
// Element stream from the sorted-result drain: valid/ready handshake carrying
// one element per transfer, tagged with its source index and end-of-stream flag.
interface sorted_stream_if #(
    parameter int WIDTH = 3,
    parameter int IDXW  = 4
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [IDXW-1:0]  out_index;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/sorted_stream_out.sv
// Drain side of the odd-even merge: captures the 2n-element sorted vector in one
// edge and streams it out ascending or descending over a valid/ready interface.
module sorted_stream_out #(
    parameter int WIDTH = 3,
    parameter int n     = 8,
    parameter int IDXW  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*n*WIDTH-1:0]   inc,
    input  logic                   start,
    input  logic                   desc,
    input  logic                   abort,
    sorted_stream_if.master        so,
    output logic                   busy,
    output logic                   done
);
    localparam int NE = 2 * n;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NE - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] elem_p0 [NE];
    logic             desc_p0;
    logic [IDXW-1:0]  ptr_p0;
    logic             done_p0;
    logic [IDXW-1:0]  end_idx;
    logic             streaming;
    logic             xfer;
    logic             final_xfer;

    assign streaming  = (state_q == STREAM);
    assign end_idx    = desc_p0 ? '0 : LAST_IDX;
    assign xfer       = streaming && so.out_ready;
    assign final_xfer = xfer && (ptr_p0 == end_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STREAM;
            STREAM:  if (abort || final_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture stage: whole vector and direction land on the start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NE; k++) begin
                elem_p0[k] <= '0;
            end
            desc_p0 <= 1'b0;
        end else if (state_q == IDLE && start) begin
            for (int k = 0; k < NE; k++) begin
                elem_p0[k] <= inc[k*WIDTH +: WIDTH];
            end
            desc_p0 <= desc;
        end
    end

    // Pointer holds on the final transfer, so it never steps past either end.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_p0 <= '0;
        end else if (state_q == IDLE && start) begin
            ptr_p0 <= desc ? LAST_IDX : '0;
        end else if (xfer && !final_xfer && !abort) begin
            ptr_p0 <= desc_p0 ? (ptr_p0 - IDXW'(1)) : (ptr_p0 + IDXW'(1));
        end
    end

    // An abort coinciding with the final transfer still suppresses completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_p0 <= 1'b0;
        end else begin
            done_p0 <= final_xfer && !abort;
        end
    end

    assign so.out_data  = elem_p0[ptr_p0];
    assign so.out_valid = streaming;
    assign so.out_last  = streaming && (ptr_p0 == end_idx);
    assign so.out_index = ptr_p0;
    assign busy         = streaming;
    assign done         = done_p0;
endmodule

// File: tb/tb_sorted_stream_out.sv
// Scoreboard bench for sorted_stream_out: expected elements are queued when a
// stream is started and popped as the DUT transfers them.
module tb_sorted_stream_out;
    localparam int WIDTH = 3;
    localparam int N     = 8;
    localparam int IDXW  = 4;
    localparam int NE    = 2 * N;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [IDXW-1:0]  i;
        logic             l;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NE*WIDTH-1:0]   inc;
    logic                  start;
    logic                  desc;
    logic                  abort;
    logic                  busy;
    logic                  done;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    sorted_stream_if #(.WIDTH(WIDTH), .IDXW(IDXW)) so ();

    sorted_stream_out #(.WIDTH(WIDTH), .n(N), .IDXW(IDXW)) dut (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .start (start),
        .desc  (desc),
        .abort (abort),
        .so    (so),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pairs();
        for (int k = 0; k < NE; k++) inc[k*WIDTH +: WIDTH] = WIDTH'(k >> 1);
    endtask

    task automatic load_random();
        for (int k = 0; k < NE; k++) inc[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 7));
    endtask

    task automatic push_exp(input logic dd);
        exp_t e;
        int   k;
        sbq.delete();
        for (int j = 0; j < NE; j++) begin
            k   = dd ? (NE - 1 - j) : j;
            e.d = inc[k*WIDTH +: WIDTH];
            e.i = IDXW'(k);
            e.l = (j == NE - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic do_start(input logic dd);
        push_exp(dd);
        start = 1'b1;
        desc  = dd;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; desc = 1'b0; abort = 1'b0; so.out_ready = 1'b0;
        load_pairs();
        tick(); tick();
        rst = 1'b0;
        tick();
        total++;
        if ({so.out_valid, busy, done, so.out_last, so.out_index, so.out_data} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b want=0", {so.out_valid, busy, done, so.out_last, so.out_index, so.out_data});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({so.out_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL idle_abort got=%b want=000", {so.out_valid, busy, done});
        end
    endtask

    task automatic test_stream(input logic dd);
        exp_t e;
        load_pairs();
        so.out_ready = 1'b1;
        do_start(dd);
        total++;
        if ({so.out_valid, busy} !== 2'b11) begin
            bad++;
            $display("FAIL stream_latency desc=%0b got=%b want=11", dd, {so.out_valid, busy});
        end
        for (int c = 0; c < NE; c++) begin
            e = sbq.pop_front();
            total++;
            if (so.out_valid !== 1'b1 || {so.out_data, so.out_index, so.out_last} !== {e.d, e.i, e.l}) begin
                bad++;
                $display("FAIL stream_elem desc=%0b cyc=%0d got v=%b d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                         dd, c, so.out_valid, so.out_data, so.out_index, so.out_last, e.d, e.i, e.l);
            end
            tick();
        end
        total++;
        if ({so.out_valid, busy, done} !== 3'b001) begin
            bad++;
            $display("FAIL stream_done desc=%0b got=%b want=001", dd, {so.out_valid, busy, done});
        end
        tick();
        total++;
        if ({so.out_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL stream_done_pulse desc=%0b got=%b want=000", dd, {so.out_valid, busy, done});
        end
    endtask

    task automatic test_backpressure();
        exp_t                     e;
        int                       accepted = 0;
        logic                     have_prev = 1'b0;
        logic [WIDTH+IDXW:0]      prev = '0;
        load_random();
        do_start(1'b0);
        for (int c = 0; c < 100 && accepted < NE; c++) begin
            so.out_ready = (c % 3 == 0);
            if (have_prev) begin
                total++;
                if ({so.out_valid, so.out_data, so.out_index, so.out_last} !== {1'b1, prev}) begin
                    bad++;
                    $display("FAIL bp_stall_hold cyc=%0d got=%b want=%b", c,
                             {so.out_valid, so.out_data, so.out_index, so.out_last}, {1'b1, prev});
                end
            end
            if (so.out_ready && so.out_valid) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra cyc=%0d got i=%0d want none", c, so.out_index);
                end else begin
                    e = sbq.pop_front();
                    if ({so.out_data, so.out_index, so.out_last} !== {e.d, e.i, e.l}) begin
                        bad++;
                        $display("FAIL bp_elem cyc=%0d got d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                                 c, so.out_data, so.out_index, so.out_last, e.d, e.i, e.l);
                    end
                end
                accepted++;
                have_prev = 1'b0;
            end else begin
                prev      = {so.out_data, so.out_index, so.out_last};
                have_prev = 1'b1;
            end
            tick();
        end
        total++;
        if (accepted != NE || {so.out_valid, busy, done} !== 3'b001) begin
            bad++;
            $display("FAIL bp_complete got acc=%0d vbd=%b want acc=%0d vbd=001",
                     accepted, {so.out_valid, busy, done}, NE);
        end
        so.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_capture_hold();
        exp_t e;
        load_pairs();
        so.out_ready = 1'b1;
        do_start(1'b0);
        for (int k = 0; k < NE; k++) inc[k*WIDTH +: WIDTH] = 3'd7;
        for (int c = 0; c < NE; c++) begin
            e = sbq.pop_front();
            total++;
            if (so.out_valid !== 1'b1 || {so.out_data, so.out_index, so.out_last} !== {e.d, e.i, e.l}) begin
                bad++;
                $display("FAIL hold_elem cyc=%0d got v=%b d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                         c, so.out_valid, so.out_data, so.out_index, so.out_last, e.d, e.i, e.l);
            end
            start = (c == 5) || (c == NE - 1);
            tick();
        end
        start = 1'b0;
        total++;
        if ({so.out_valid, busy, done} !== 3'b001) begin
            bad++;
            $display("FAIL hold_done got=%b want=001", {so.out_valid, busy, done});
        end
        tick();
        total++;
        if ({so.out_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL hold_no_restart got=%b want=000", {so.out_valid, busy, done});
        end
    endtask

    task automatic test_abort();
        exp_t e;
        load_pairs();
        so.out_ready = 1'b1;
        do_start(1'b0);
        for (int c = 0; c <= 9; c++) begin
            e = sbq.pop_front();
            total++;
            if ({so.out_valid, so.out_data, so.out_index, so.out_last} !== {1'b1, e.d, e.i, e.l}) begin
                bad++;
                $display("FAIL abort_elem cyc=%0d got d=%0d i=%0d want d=%0d i=%0d",
                         c, so.out_data, so.out_index, e.d, e.i);
            end
            abort = (c == 9);
            tick();
        end
        abort = 1'b0;
        total++;
        if ({so.out_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL abort_stop got=%b want=000", {so.out_valid, busy, done});
        end
        tick();
        total++;
        if ({so.out_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL abort_no_done got=%b want=000", {so.out_valid, busy, done});
        end
        load_random();
        do_start(1'b0);
        for (int c = 0; c < NE; c++) begin
            e = sbq.pop_front();
            total++;
            if ({so.out_valid, so.out_data, so.out_index, so.out_last} !== {1'b1, e.d, e.i, e.l}) begin
                bad++;
                $display("FAIL abort_restart cyc=%0d got v=%b d=%0d i=%0d l=%b want d=%0d i=%0d l=%b",
                         c, so.out_valid, so.out_data, so.out_index, so.out_last, e.d, e.i, e.l);
            end
            tick();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart_done got=%b want=1", done);
        end
        tick();
    endtask

    task automatic test_rst_midstream();
        exp_t e;
        load_pairs();
        so.out_ready = 1'b1;
        do_start(1'b1);
        for (int c = 0; c < 4; c++) begin
            e = sbq.pop_front();
            total++;
            if ({so.out_data, so.out_index} !== {e.d, e.i}) begin
                bad++;
                $display("FAIL rst_pre_elem cyc=%0d got d=%0d i=%0d want d=%0d i=%0d",
                         c, so.out_data, so.out_index, e.d, e.i);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({so.out_valid, busy, done, so.out_last, so.out_index, so.out_data} !== '0) begin
                bad++;
                $display("FAIL rst_mid_state cyc=%0d got=%b want=0", c,
                         {so.out_valid, busy, done, so.out_last, so.out_index, so.out_data});
            end
            tick();
        end
        sbq.delete();
    endtask

    initial begin
        test_reset();
        test_stream(1'b0);
        test_stream(1'b1);
        test_backpressure();
        test_capture_hold();
        test_abort();
        test_rst_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
